// File: rtl/boot_ram_loader.sv
// Boot image loader: takes bytes from the flash reader and writes them into
// the Z8S180 external SRAM at consecutive addresses, holding the CPU in reset
// while it owns the bus. Releases bus and CPU on success; latches an error and
// keeps the CPU in reset on a short stream or receive overflow.
module boot_ram_loader #(
    parameter int                    NUM_BYTES     = 16,
    parameter int                    ADDR_WIDTH    = 20,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE_ADDR = '0,
    parameter int                    WE_PULSE_CLKS = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  flash_read_en,
    input  logic                  flash_read_active,
    input  logic                  flash_tValid,
    input  logic [7:0]            flash_tData,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_data,
    output logic                  ram_ce_n,
    output logic                  ram_we_n,
    output logic                  bus_own,
    output logic                  cpu_reset_n,
    output logic                  load_done,
    output logic                  load_error,
    output logic [7:0]            checksum
);

    // One spare bit so the byte counters can reach NUM_BYTES and still
    // saturate above it without wrapping back into the valid range.
    localparam int CW = $clog2(NUM_BYTES + 1) + 1;
    localparam int PW = (WE_PULSE_CLKS > 1) ? $clog2(WE_PULSE_CLKS) : 1;
    localparam logic [CW:0]   NB_EXT   = (CW+1)'(NUM_BYTES);
    localparam logic [CW-1:0] NB_CNT   = CW'(NUM_BYTES);
    localparam logic [PW-1:0] PULSE_LAST = PW'(WE_PULSE_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_SETUP, S_PULSE, S_HOLD, S_DONE, S_ERROR
    } state_t;

    state_t state, state_nxt;

    logic [7:0]    fifo_mem [2];
    logic          fifo_wp, fifo_rp;
    logic [1:0]    fifo_cnt;
    logic [CW-1:0] rx_count, wr_count;
    logic [CW:0]   rx_total;
    logic [PW-1:0] pulse_cnt;
    logic          act_q;
    logic          rx_window, push_req, push, pop, overflow, short_err, err;
    logic          in_cycle;

    // Bytes are accepted only while a load is in progress.
    assign rx_window = (state == S_REQ) || (state == S_WAIT) || (state == S_SETUP) ||
                       (state == S_PULSE) || (state == S_HOLD);
    assign push_req  = flash_tValid && rx_window;
    assign overflow  = push_req && (fifo_cnt == 2'd2);
    assign push      = push_req && !overflow;
    assign rx_total  = {1'b0, rx_count} + {{CW{1'b0}}, push};
    // Reader went idle before the full image arrived (same-cycle push counts).
    assign short_err = rx_window && act_q && !flash_read_active && (rx_total < NB_EXT);
    assign err       = overflow || short_err;
    assign pop       = (state == S_WAIT) && (state_nxt == S_SETUP);
    assign in_cycle  = (state == S_SETUP) || (state == S_PULSE) || (state == S_HOLD);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; error detection overrides every normal transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   if (flash_read_active) state_nxt = S_WAIT;
            S_WAIT: begin
                if (wr_count == NB_CNT)     state_nxt = S_DONE;
                else if (fifo_cnt != 2'd0)  state_nxt = S_SETUP;
            end
            S_SETUP: state_nxt = S_PULSE;
            S_PULSE: if (pulse_cnt == PULSE_LAST) state_nxt = S_HOLD;
            S_HOLD:  state_nxt = S_WAIT;
            default: state_nxt = state;
        endcase
        if (err) state_nxt = S_ERROR;
    end

    // Receive FIFO, counters, and the address/data latch for each write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wp     <= 1'b0;
            fifo_rp     <= 1'b0;
            fifo_cnt    <= '0;
            rx_count    <= '0;
            wr_count    <= '0;
            pulse_cnt   <= '0;
            act_q       <= 1'b0;
            ram_addr    <= '0;
            ram_data    <= '0;
            checksum    <= '0;
        end else begin
            act_q <= flash_read_active;
            if (push) begin
                fifo_mem[fifo_wp] <= flash_tData;
                fifo_wp           <= ~fifo_wp;
                if (rx_count != {CW{1'b1}}) rx_count <= rx_count + 1'b1;
            end
            if (pop) fifo_rp <= ~fifo_rp;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            // Address and data move only when a new write cycle starts.
            if (pop) begin
                ram_addr <= RAM_BASE_ADDR + ADDR_WIDTH'(wr_count);
                ram_data <= fifo_mem[fifo_rp];
            end
            if (state == S_SETUP)      pulse_cnt <= '0;
            else if (state == S_PULSE) pulse_cnt <= pulse_cnt + 1'b1;
            // An aborted cycle is neither counted nor summed.
            if (state == S_HOLD && state_nxt == S_WAIT) begin
                checksum <= checksum + ram_data;
                wr_count <= wr_count + 1'b1;
            end
        end
    end

    // Registered outputs. Strobes follow the current state one clock late so
    // address/data get a full clock of setup; status flags follow the next
    // state so DONE/ERROR become visible on the edge that enters them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flash_read_en <= 1'b0;
            ram_ce_n      <= 1'b1;
            ram_we_n      <= 1'b1;
            bus_own       <= 1'b1;
            cpu_reset_n   <= 1'b0;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
        end else begin
            flash_read_en <= (state_nxt == S_REQ) || (state_nxt == S_WAIT) ||
                             (state_nxt == S_SETUP) || (state_nxt == S_PULSE) ||
                             (state_nxt == S_HOLD);
            // Entering ERROR drops both strobes at once, aborting any write.
            ram_ce_n      <= (state_nxt == S_ERROR) ? 1'b1 : !in_cycle;
            ram_we_n      <= (state_nxt == S_ERROR) ? 1'b1 : (state != S_PULSE);
            bus_own       <= (state_nxt != S_DONE);
            cpu_reset_n   <= (state_nxt == S_DONE);
            load_done     <= (state_nxt == S_DONE);
            load_error    <= (state_nxt == S_ERROR);
        end
    end

endmodule

// File: tb/tb_boot_ram_loader.sv
// Directed bench: three loader instances share one flash stream (default,
// 3-clock WE pulse, and a 4-byte image wrapping past the top of the SRAM).
module tb_boot_ram_loader;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic act = 1'b0, tvalid = 1'b0;
    logic [7:0] tdata = '0;

    logic [2:0]  en, ce, we, bown, cpur, done, err;
    logic [19:0] addr [3];
    logic [7:0]  data [3];
    logic [7:0]  cks  [3];

    int n_cmp = 0, n_err = 0;
    logic [7:0] bytes [16];

    always #20 clock = ~clock;

    boot_ram_loader u_dut (
        .clock(clock), .reset_n(reset_n), .flash_read_en(en[0]),
        .flash_read_active(act), .flash_tValid(tvalid), .flash_tData(tdata),
        .ram_addr(addr[0]), .ram_data(data[0]), .ram_ce_n(ce[0]), .ram_we_n(we[0]),
        .bus_own(bown[0]), .cpu_reset_n(cpur[0]), .load_done(done[0]),
        .load_error(err[0]), .checksum(cks[0]));

    boot_ram_loader #(.WE_PULSE_CLKS(3)) u_w3 (
        .clock(clock), .reset_n(reset_n), .flash_read_en(en[1]),
        .flash_read_active(act), .flash_tValid(tvalid), .flash_tData(tdata),
        .ram_addr(addr[1]), .ram_data(data[1]), .ram_ce_n(ce[1]), .ram_we_n(we[1]),
        .bus_own(bown[1]), .cpu_reset_n(cpur[1]), .load_done(done[1]),
        .load_error(err[1]), .checksum(cks[1]));

    boot_ram_loader #(.NUM_BYTES(4), .RAM_BASE_ADDR(20'hFFFFE)) u_wrap (
        .clock(clock), .reset_n(reset_n), .flash_read_en(en[2]),
        .flash_read_active(act), .flash_tValid(tvalid), .flash_tData(tdata),
        .ram_addr(addr[2]), .ram_data(data[2]), .ram_ce_n(ce[2]), .ram_we_n(we[2]),
        .bus_own(bown[2]), .cpu_reset_n(cpur[2]), .load_done(done[2]),
        .load_error(err[2]), .checksum(cks[2]));

    // Write monitor: logs {addr,data} on each ram_we_n fall and tracks strobe
    // widths and address/data stability while ram_ce_n is low.
    logic [27:0] wlog [3][32];
    int wcnt [3], we_run [3], ce_run [3], we_min [3], we_max [3], ce_min [3], ce_max [3];
    logic [2:0] we_p, ce_p, unstable;
    logic [19:0] addr_p [3];
    logic [7:0]  data_p [3];

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                wcnt[i] <= 0; we_run[i] <= 0; ce_run[i] <= 0;
                we_min[i] <= 99; we_max[i] <= 0; ce_min[i] <= 99; ce_max[i] <= 0;
                unstable[i] <= 1'b0; we_p[i] <= 1'b1; ce_p[i] <= 1'b1;
            end else begin
                if (!we[i] && we_p[i] && wcnt[i] < 32) begin
                    wlog[i][wcnt[i]] <= {addr[i], data[i]};
                    wcnt[i] <= wcnt[i] + 1;
                end
                if (!we[i]) we_run[i] <= we_run[i] + 1;
                else if (we_run[i] > 0) begin
                    if (we_run[i] < we_min[i]) we_min[i] <= we_run[i];
                    if (we_run[i] > we_max[i]) we_max[i] <= we_run[i];
                    we_run[i] <= 0;
                end
                if (!ce[i]) ce_run[i] <= ce_run[i] + 1;
                else if (ce_run[i] > 0) begin
                    if (ce_run[i] < ce_min[i]) ce_min[i] <= ce_run[i];
                    if (ce_run[i] > ce_max[i]) ce_max[i] <= ce_run[i];
                    ce_run[i] <= 0;
                end
                if (!ce[i] && !ce_p[i] && (addr[i] !== addr_p[i] || data[i] !== data_p[i]))
                    unstable[i] <= 1'b1;
                we_p[i] <= we[i]; ce_p[i] <= ce[i];
                addr_p[i] <= addr[i]; data_p[i] <= data[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic strobe(input logic [7:0] b);
        tvalid = 1'b1; tdata = b;
        @(negedge clock);
        tvalid = 1'b0;
    endtask

    task automatic start();
        reset_n = 1'b0; act = 1'b0; tvalid = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        act = 1'b1;
        tick(2);
    endtask

    task automatic send(input int n);
        for (int k = 0; k < n; k++) begin
            strobe(bytes[k]);
            tick(15);
        end
    endtask

    task automatic wait_end(input int i, input string tag);
        int k;
        k = 0;
        while (!(done[i] || err[i]) && k < 200) begin
            tick(1);
            k++;
        end
        chk({tag, "_terminated"}, 32'(k < 200), 1);
    endtask

    task automatic check_image(input int i, input int n, input string tag, input logic [19:0] base);
        logic [7:0]  sum;
        logic [19:0] ea;
        sum = '0;
        chk({tag, "_writes"}, wcnt[i], n);
        for (int k = 0; k < n; k++) begin
            ea = base + 20'(k);
            chk($sformatf("%s_addr%0d", tag, k), wlog[i][k][27:8], ea);
            chk($sformatf("%s_data%0d", tag, k), wlog[i][k][7:0], bytes[k]);
            sum = sum + bytes[k];
        end
        chk({tag, "_checksum"}, cks[i], sum);
    endtask

    initial begin
        int k;
        void'($urandom(32'h13427465));
        for (int j = 0; j < 16; j++) bytes[j] = 8'($urandom);

        // Reset state
        reset_n = 1'b0;
        tick(2);
        chk("rst_read_en", en[0], 0);
        chk("rst_ce_n", ce[0], 1);
        chk("rst_we_n", we[0], 1);
        chk("rst_addr", addr[0], 0);
        chk("rst_data", data[0], 0);
        chk("rst_bus_own", bown[0], 1);
        chk("rst_cpu_reset_n", cpur[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_error", err[0], 0);
        chk("rst_checksum", cks[0], 0);

        // Nominal 16-byte load on all three instances
        reset_n = 1'b1;
        tick(1);
        chk("idle_to_req_read_en", en[0], 1);
        tick(2);
        act = 1'b1;
        tick(2);
        send(16);
        act = 1'b0;
        wait_end(0, "nom");
        tick(10);
        check_image(0, 16, "nom", 20'h00000);
        chk("nom_done", done[0], 1);
        chk("nom_cpu_reset_n", cpur[0], 1);
        chk("nom_bus_own", bown[0], 0);
        chk("nom_error", err[0], 0);
        chk("nom_read_en", en[0], 0);
        check_image(1, 16, "w3", 20'h00000);
        chk("w3_done", done[1], 1);
        chk("w3_we_min", we_min[1], 3);
        chk("w3_we_max", we_max[1], 3);
        chk("w3_ce_min", ce_min[1], 5);
        chk("w3_ce_max", ce_max[1], 5);
        chk("w3_unstable", unstable[1], 0);
        check_image(2, 4, "wrap", 20'hFFFFE);
        chk("wrap_addr2_zero", wlog[2][2][27:8], 20'h00000);
        chk("wrap_done", done[2], 1);
        chk("wrap_error", err[2], 0);

        // Short stream: reader goes idle after 10 bytes
        start();
        send(10);
        act = 1'b0;
        tick(20);
        chk("short_error", err[0], 1);
        chk("short_writes", wcnt[0], 10);
        chk("short_cpu_reset_n", cpur[0], 0);
        chk("short_bus_own", bown[0], 1);
        chk("short_read_en", en[0], 0);
        chk("short_done", done[0], 0);

        // Three back-to-back strobes fit in the FIFO
        start();
        tvalid = 1'b1; tdata = bytes[0];
        @(negedge clock); tdata = bytes[1];
        @(negedge clock); tdata = bytes[2];
        @(negedge clock); tvalid = 1'b0;
        tick(30);
        chk("b2b3_error", err[0], 0);
        chk("b2b3_writes", wcnt[0], 3);
        for (int j = 0; j < 3; j++)
            chk($sformatf("b2b3_data%0d", j), wlog[0][j][7:0], bytes[j]);

        // Four back-to-back strobes overflow on the 4th push edge
        start();
        tvalid = 1'b1; tdata = 8'h5A;
        repeat (3) @(posedge clock);
        #1;
        chk("b2b4_ce_low_before", ce[0], 0);
        chk("b2b4_error_before", err[0], 0);
        @(posedge clock);
        #1;
        chk("b2b4_error", err[0], 1);
        chk("b2b4_ce_abort", ce[0], 1);
        chk("b2b4_we_abort", we[0], 1);
        @(negedge clock); tvalid = 1'b0;
        tick(5);
        chk("b2b4_writes", wcnt[0], 0);
        chk("b2b4_cpu_reset_n", cpur[0], 0);

        // Reset during byte 5's write pulse, then a full reload
        start();
        send(4);
        strobe(bytes[4]);
        k = 0;
        while (we[0] !== 1'b0 && k < 20) begin
            tick(1);
            k++;
        end
        chk("midrst_pulse_seen", 32'(k < 20), 1);
        #5;
        chk("midrst_writes_before", wcnt[0], 5);
        reset_n = 1'b0;
        #1;
        chk("midrst_we_n", we[0], 1);
        chk("midrst_ce_n", ce[0], 1);
        chk("midrst_checksum", cks[0], 0);
        chk("midrst_addr", addr[0], 0);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        act = 1'b1;
        tick(2);
        send(16);
        act = 1'b0;
        wait_end(0, "reload");
        check_image(0, 16, "reload", 20'h00000);
        chk("reload_done", done[0], 1);
        chk("reload_error", err[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
